// File: rtl/hamming_pkg.sv
// Shared types and widths for the Hamming(7,4) decode path.
package hamming_pkg;

  localparam int CODE_W     = 7;
  localparam int SYNDROME_W = 3;

  typedef logic [CODE_W-1:0]     codeword_t;
  typedef logic [SYNDROME_W-1:0] syndrome_t;

  typedef enum logic {SETTLING, STABLE} deb_state_e;

endpackage

// File: rtl/switch_debounce_capture_if.sv
// Codeword delivery bus from the switch capture stage to the syndrome detector.
interface switch_debounce_capture_if import hamming_pkg::*; #(
  parameter int WIDTH = CODE_W
);

  logic [WIDTH-1:0] data_raw;
  logic             data_valid;
  logic             data_ready;
  logic             stable;
  logic             overrun;

  modport master (
    output data_raw, data_valid, stable, overrun,
    input  data_ready
  );

  modport slave (
    input  data_raw, data_valid, stable, overrun,
    output data_ready
  );

endinterface

// File: rtl/switch_debounce_capture_sync_ff.sv
// Plain N-stage flop synchronizer for asynchronous board inputs.
module sync_ff #(
  parameter int WIDTH  = 7,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] stage_q [STAGES];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < STAGES; i++) stage_q[i] <= '0;
    end else begin
      stage_q[0] <= d_i;
      for (int i = 1; i < STAGES; i++) stage_q[i] <= stage_q[i-1];
    end
  end

  assign q_o = stage_q[STAGES-1];

endmodule

// File: rtl/switch_debounce_capture.sv
// Synchronizes and debounces the DIP switch word, then hands each new stable
// codeword to the decoder over a valid/ready bus with a sticky overrun flag.
module switch_debounce_capture import hamming_pkg::*; #(
  parameter int WIDTH           = CODE_W,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 270000
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [WIDTH-1:0]          sw_in,
  switch_debounce_capture_if.master cap
);

  localparam int                CNT_W   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0]  DEB_MAX = CNT_W'(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0]  DEB_PRE = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [WIDTH-1:0] sync_w;
  logic [WIDTH-1:0] cand_q, cand_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             valid_q, valid_d;
  logic             ovr_q, ovr_d;
  logic             commit;
  deb_state_e       state;

  sync_ff #(
    .WIDTH  (WIDTH),
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d_i   (sw_in),
    .q_o   (sync_w)
  );

  // Saturated counter is the STABLE state; it never re-commits while holding.
  assign state = (cnt_q == DEB_MAX) ? STABLE : SETTLING;

  always_comb begin
    cand_d  = cand_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    valid_d = valid_q;
    ovr_d   = ovr_q;
    commit  = 1'b0;

    if (sync_w != cand_q) begin
      cand_d = sync_w;
      cnt_d  = '0;
    end else if (state == SETTLING) begin
      cnt_d  = cnt_q + CNT_W'(1);
      commit = (cnt_q == DEB_PRE);
    end

    if (valid_q && cap.data_ready) valid_d = 1'b0;

    // A commit landing on a handshake edge is not an overrun: the old word was taken.
    if (commit && (cand_q != data_q)) begin
      if (valid_d) ovr_d = 1'b1;
      data_d  = cand_q;
      valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cand_q  <= '0;
      cnt_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      cand_q  <= cand_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ovr_q   <= ovr_d;
    end
  end

  assign cap.data_raw   = data_q;
  assign cap.data_valid = valid_q;
  assign cap.stable     = (state == STABLE);
  assign cap.overrun    = ovr_q;

endmodule

// File: tb/tb_switch_debounce_capture.sv
// Bench for switch_debounce_capture: directed scenarios plus random traffic,
// checked against a timestamp-based model of the debounce rules.
module tb_switch_debounce_capture;
  import hamming_pkg::*;

  localparam int DEB = 4;

  logic      clk = 1'b0;
  logic      rst_n = 1'b0;
  codeword_t sw_in = '0;
  int        total = 0;
  int        bad = 0;

  switch_debounce_capture_if #(.WIDTH(7)) bus ();

  switch_debounce_capture #(
    .WIDTH           (7),
    .SYNC_STAGES     (2),
    .DEBOUNCE_CYCLES (DEB)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .sw_in (sw_in),
    .cap   (bus)
  );

  always #5 clk = ~clk;

  // Model: the word seen after synchronization is sw_in from two edges back;
  // a candidate is committed when it has been seen unchanged for DEB edges.
  codeword_t m_s1 = '0, m_s2 = '0, m_sv = '0, m_cand = '0, m_data = '0;
  logic      m_valid = 1'b0, m_ovr = 1'b0, m_stable = 1'b0;
  int        m_edge = 0, m_since = 0;

  always @(posedge clk) begin
    m_edge++;
    if (!rst_n) begin
      m_s1 = '0; m_s2 = '0; m_cand = '0; m_since = m_edge;
      m_data = '0; m_valid = 1'b0; m_ovr = 1'b0;
    end else begin
      m_sv = m_s2;
      m_s2 = m_s1;
      m_s1 = sw_in;
      if (m_valid && bus.data_ready) m_valid = 1'b0;
      if (m_sv != m_cand) begin
        m_cand  = m_sv;
        m_since = m_edge;
      end else if ((m_edge - m_since) == DEB && m_cand != m_data) begin
        if (m_valid) m_ovr = 1'b1;
        m_data  = m_cand;
        m_valid = 1'b1;
      end
    end
    m_stable = ((m_edge - m_since) >= DEB);
  end

  wire [9:0] got_v = {bus.data_raw, bus.data_valid, bus.stable, bus.overrun};
  wire [9:0] exp_v = {m_data, m_valid, m_stable, m_ovr};

  task automatic test_reset();
    rst_n = 1'b0; sw_in = 7'h55; bus.data_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk); total++;
      if (got_v !== 10'h000) begin bad++; $display("FAIL reset_outputs cyc=%0d got=%h want=000", k, got_v); end
    end
  endtask

  task automatic test_first_commit();
    rst_n = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk); total++;
      if (got_v !== exp_v) begin bad++; $display("FAIL first_model k=%0d got=%h want=%h", k, got_v, exp_v); end
      total++;
      if (k < 7 && bus.data_valid !== 1'b0) begin bad++; $display("FAIL first_early k=%0d valid=%b want=0", k, bus.data_valid); end
      else if (k == 7 && {bus.data_raw, bus.data_valid, bus.stable} !== {7'h55, 1'b1, 1'b1}) begin
        bad++; $display("FAIL first_commit raw=%h valid=%b stable=%b want 55/1/1", bus.data_raw, bus.data_valid, bus.stable);
      end
    end
  endtask

  task automatic test_bounce();
    bus.data_ready = 1'b1;
    @(negedge clk); total++;
    if (bus.data_valid !== 1'b0) begin bad++; $display("FAIL bounce_consume valid=%b want=0", bus.data_valid); end
    bus.data_ready = 1'b0;
    for (int i = 0; i < 20; i++) begin
      sw_in = (((i / 2) % 2) == 0) ? 7'h54 : 7'h55;
      @(negedge clk); total++;
      if (got_v !== exp_v) begin bad++; $display("FAIL bounce_model i=%0d got=%h want=%h", i, got_v, exp_v); end
      total++;
      if (bus.data_valid !== 1'b0 || (i >= 2 && bus.stable !== 1'b0)) begin
        bad++; $display("FAIL bounce_quiet i=%0d valid=%b stable=%b want 0/0", i, bus.data_valid, bus.stable);
      end
    end
    sw_in = 7'h54;
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk); total++;
      if (got_v !== exp_v) begin bad++; $display("FAIL settle_model k=%0d got=%h want=%h", k, got_v, exp_v); end
      total++;
      if (k < 7 && bus.data_valid !== 1'b0) begin bad++; $display("FAIL settle_early k=%0d valid=%b want=0", k, bus.data_valid); end
      else if (k >= 7 && {bus.data_raw, bus.data_valid, bus.overrun} !== {7'h54, 1'b1, 1'b0}) begin
        bad++; $display("FAIL settle_commit k=%0d raw=%h valid=%b ovr=%b want 54/1/0", k, bus.data_raw, bus.data_valid, bus.overrun);
      end
    end
  endtask

  task automatic test_hold();
    for (int k = 0; k < 10; k++) begin
      @(negedge clk); total++;
      if ({bus.data_raw, bus.data_valid} !== {7'h54, 1'b1}) begin
        bad++; $display("FAIL hold k=%0d raw=%h valid=%b want 54/1", k, bus.data_raw, bus.data_valid);
      end
    end
    bus.data_ready = 1'b1;
    @(negedge clk); total++;
    if (bus.data_valid !== 1'b0 || got_v !== exp_v) begin bad++; $display("FAIL hold_release got=%h want=%h", got_v, exp_v); end
    bus.data_ready = 1'b0;
  endtask

  task automatic test_overrun();
    sw_in = 7'h55;
    repeat (7) @(negedge clk);
    total++;
    if ({bus.data_raw, bus.data_valid, bus.overrun} !== {7'h55, 1'b1, 1'b0}) begin
      bad++; $display("FAIL ovr_first raw=%h valid=%b ovr=%b want 55/1/0", bus.data_raw, bus.data_valid, bus.overrun);
    end
    sw_in = 7'h2A;
    repeat (7) @(negedge clk);
    total++;
    if ({bus.data_raw, bus.data_valid, bus.overrun} !== {7'h2A, 1'b1, 1'b1}) begin
      bad++; $display("FAIL ovr_second raw=%h valid=%b ovr=%b want 2a/1/1", bus.data_raw, bus.data_valid, bus.overrun);
    end
    bus.data_ready = 1'b1;
    @(negedge clk);
    bus.data_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk); total++;
      if ({bus.data_valid, bus.overrun} !== 2'b01 || got_v !== exp_v) begin
        bad++; $display("FAIL ovr_sticky k=%0d got=%h want=%h", k, got_v, exp_v);
      end
    end
  endtask

  task automatic test_commit_handshake();
    rst_n = 1'b0; sw_in = 7'h00;
    repeat (2) @(negedge clk);
    rst_n = 1'b1; sw_in = 7'h70;
    repeat (7) @(negedge clk);
    total++;
    if ({bus.data_raw, bus.data_valid} !== {7'h70, 1'b1}) begin
      bad++; $display("FAIL hs_setup raw=%h valid=%b want 70/1", bus.data_raw, bus.data_valid);
    end
    sw_in = 7'h0F;
    for (int k = 1; k <= 7; k++) begin
      bus.data_ready = (k == 7);
      @(negedge clk); total++;
      if (got_v !== exp_v) begin bad++; $display("FAIL hs_model k=%0d got=%h want=%h", k, got_v, exp_v); end
    end
    bus.data_ready = 1'b0;
    total++;
    if ({bus.data_raw, bus.data_valid, bus.overrun} !== {7'h0F, 1'b1, 1'b0}) begin
      bad++; $display("FAIL hs_commit raw=%h valid=%b ovr=%b want 0f/1/0", bus.data_raw, bus.data_valid, bus.overrun);
    end
  endtask

  task automatic test_reset_mid_settle();
    sw_in = 7'h33;
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk); total++;
    if (got_v !== 10'h000) begin bad++; $display("FAIL midreset_clear got=%h want=000", got_v); end
    rst_n = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk); total++;
      if (got_v !== exp_v) begin bad++; $display("FAIL midreset_model k=%0d got=%h want=%h", k, got_v, exp_v); end
      total++;
      if (k < 7 && {bus.data_raw, bus.data_valid} !== 8'h00) begin
        bad++; $display("FAIL midreset_early k=%0d raw=%h valid=%b want 00/0", k, bus.data_raw, bus.data_valid);
      end else if (k == 7 && {bus.data_raw, bus.data_valid, bus.stable} !== {7'h33, 1'b1, 1'b1}) begin
        bad++; $display("FAIL midreset_commit raw=%h valid=%b stable=%b want 33/1/1", bus.data_raw, bus.data_valid, bus.stable);
      end
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      int r;
      r = int'($urandom_range(0, 99));
      if (r < 12) sw_in = 7'($urandom);
      else if (r < 20) sw_in[0] = ~sw_in[0];
      bus.data_ready = ($urandom_range(0, 3) == 0);
      rst_n = ($urandom_range(0, 79) != 0);
      @(negedge clk); total++;
      if (got_v !== exp_v) begin bad++; $display("FAIL random c=%0d got=%h want=%h", c, got_v, exp_v); end
    end
    rst_n = 1'b1;
  endtask

  initial begin
    bus.data_ready = 1'b0;
    test_reset();
    test_first_commit();
    test_bounce();
    test_hold();
    test_overrun();
    test_commit_handshake();
    test_reset_mid_settle();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
